// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load/store unit: sized accesses, req/ack data-memory
// handshake with stall, misalign/illegal/timeout exceptions and flush handling.
module mem_stage_lsu #(
  parameter int XLEN      = 32,
  parameter int WB_CTRL_W = 3,
  parameter int RD_W      = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_memread,
  input  logic                 in_memwrite,
  input  logic [2:0]           in_funct3,
  input  logic [WB_CTRL_W-1:0] in_ctrl_wb,
  input  logic [RD_W-1:0]      in_rd,
  input  logic [XLEN-1:0]      in_pc4,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_store_data,
  input  logic                 flush_i,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN/8-1:0]    dmem_be,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 mem_stall,
  output logic                 wb_valid,
  output logic [WB_CTRL_W-1:0] wb_ctrl,
  output logic [RD_W-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_pc4,
  output logic [XLEN-1:0]      wb_alu_data,
  output logic [XLEN-1:0]      wb_mem_data,
  output logic [1:0]           wb_exc
);

  localparam int BW = XLEN / 8;
  localparam int LG = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_kill;

  logic [1:0]      w_sz;
  logic [LG-1:0]   w_off;
  logic [LG-1:0]   w_amask;
  logic [BW-1:0]   w_bmask;
  logic            w_legal;
  logic            w_misal;
  logic            w_access;
  logic            w_memop;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tmo;
  logic [XLEN-1:0] w_rsh;
  logic [XLEN-1:0] w_ldata;
  logic            w_done;
  logic [1:0]      w_exc;
  logic            w_wb_valid;
  logic            w_ld_cap;

  assign w_sz  = in_funct3[1:0];
  assign w_off = in_alu_result[LG-1:0];

  always_comb begin
    w_legal = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b011:                 w_legal = (XLEN == 64);
      3'b100, 3'b101:         w_legal = !in_memwrite;
      3'b110:                 w_legal = (XLEN == 64) && !in_memwrite;
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_amask = '0;
    w_bmask = '0;
    case (w_sz)
      2'd0: begin w_amask = LG'(0); w_bmask = BW'(8'h01); end
      2'd1: begin w_amask = LG'(1); w_bmask = BW'(8'h03); end
      2'd2: begin w_amask = LG'(3); w_bmask = BW'(8'h0F); end
      default: begin w_amask = LG'(7); w_bmask = BW'(8'hFF); end
    endcase
  end

  assign w_misal  = |(w_off & w_amask);
  assign w_access = in_valid & (in_memread | in_memwrite) & !flush_i;
  assign w_memop  = w_access & w_legal & !w_misal;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_tmo     = (TIMEOUT != 0) && (r_state == S_BUSY) && !dmem_ack &&
                     (w_cnt_inc == CW'(TIMEOUT));

  assign dmem_req  = reset_n & (((r_state == S_IDLE) & w_memop) | (r_state == S_BUSY));
  assign mem_stall = reset_n & (((r_state == S_IDLE) & w_memop & !dmem_ack) |
                                ((r_state == S_BUSY) & !dmem_ack & !w_tmo));
  assign dmem_we   = in_memwrite;
  assign dmem_addr = {in_alu_result[XLEN-1:LG], {LG{1'b0}}};
  assign dmem_be   = w_bmask << w_off;

  always_comb begin
    dmem_wdata = in_store_data;
    case (w_sz)
      2'd0:    dmem_wdata = {BW{in_store_data[7:0]}};
      2'd1:    dmem_wdata = {(BW/2){in_store_data[15:0]}};
      2'd2:    dmem_wdata = {(BW/4){in_store_data[31:0]}};
      default: dmem_wdata = in_store_data;
    endcase
  end

  assign w_rsh = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_ldata = w_rsh;
    case (in_funct3)
      3'b000:  w_ldata = XLEN'($signed(w_rsh[7:0]));
      3'b001:  w_ldata = XLEN'($signed(w_rsh[15:0]));
      3'b010:  w_ldata = XLEN'($signed(w_rsh[31:0]));
      3'b100:  w_ldata = XLEN'(w_rsh[7:0]);
      3'b101:  w_ldata = XLEN'(w_rsh[15:0]);
      3'b110:  w_ldata = XLEN'(w_rsh[31:0]);
      default: w_ldata = w_rsh;
    endcase
  end

  // Illegal size takes priority over misalignment; a kill (flag or same-cycle
  // flush in BUSY) still lets the bus transaction finish but drops its result.
  always_comb begin
    w_done = 1'b0;
    w_exc  = 2'b00;
    if (r_state == S_IDLE) begin
      if (in_valid && !flush_i) begin
        if (w_access && !w_legal) begin
          w_done = 1'b1;
          w_exc  = 2'b11;
        end else if (w_access && w_misal) begin
          w_done = 1'b1;
          w_exc  = 2'b01;
        end else if (w_memop) begin
          w_done = dmem_ack;
        end else begin
          w_done = 1'b1;
        end
      end
    end else begin
      if (dmem_ack) begin
        w_done = 1'b1;
      end else if (w_tmo) begin
        w_done = 1'b1;
        w_exc  = 2'b10;
      end
    end
  end

  assign w_wb_valid = w_done & !((r_state == S_BUSY) & (r_kill | flush_i));
  assign w_ld_cap   = w_wb_valid & (w_exc == 2'b00) & in_memread & !in_memwrite;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_kill      <= 1'b0;
      wb_valid    <= 1'b0;
      wb_ctrl     <= '0;
      wb_rd       <= '0;
      wb_pc4      <= '0;
      wb_alu_data <= '0;
      wb_mem_data <= '0;
      wb_exc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop && !dmem_ack) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(1);
            r_kill  <= 1'b0;
          end
        end
        default: begin
          if (dmem_ack || w_tmo) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kill  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (flush_i) r_kill <= 1'b1;
          end
        end
      endcase
      wb_valid    <= w_wb_valid;
      wb_ctrl     <= w_wb_valid ? in_ctrl_wb : '0;
      wb_rd       <= in_rd;
      wb_pc4      <= in_pc4;
      wb_alu_data <= in_alu_result;
      wb_mem_data <= w_ld_cap ? w_ldata : '0;
      wb_exc      <= w_wb_valid ? w_exc : 2'b00;
    end
  end

endmodule
